// File: rtl/casex_pkg.sv
// Shared types, legacy decode table and the wildcard match helper for the
// programmable casex classifier.
package casex_pkg;

  localparam int MATCH_W  = 64;
  localparam int LEGACY_W = 3;

  typedef struct packed {
    logic                en;
    logic [LEGACY_W-1:0] value;
    logic [LEGACY_W-1:0] mask;
    logic                out;
  } entry_t;

  // Legacy fixed decode: 000->1, 001->1, 01?->0, 1??->0
  localparam entry_t LEGACY_E0 = '{en: 1'b1, value: 3'b000, mask: 3'b111, out: 1'b1};
  localparam entry_t LEGACY_E1 = '{en: 1'b1, value: 3'b001, mask: 3'b111, out: 1'b1};
  localparam entry_t LEGACY_E2 = '{en: 1'b1, value: 3'b010, mask: 3'b110, out: 1'b0};
  localparam entry_t LEGACY_E3 = '{en: 1'b1, value: 3'b100, mask: 3'b100, out: 1'b0};

  function automatic logic pat_match(
    input logic [MATCH_W-1:0] value,
    input logic [MATCH_W-1:0] mask,
    input logic [MATCH_W-1:0] in
  );
    return (((in ^ value) & mask) == {MATCH_W{1'b0}});
  endfunction

endpackage

// File: rtl/casex_classifier_chk.sv
// Run-time sanity properties on the classifier outputs.
module casex_classifier_chk #(
  parameter int   IDX_W       = 2,
  parameter int   CNT_W       = 8,
  parameter logic DEFAULT_OUT = 1'b0
) (
  input logic             clk,
  input logic             rstn,
  input logic             in_valid,
  input logic             clr_cnt,
  input logic             out_valid,
  input logic             out_hit,
  input logic [IDX_W-1:0] out_idx,
  input logic             dataOut,
  input logic [CNT_W-1:0] miss_count
);

  a_miss_outputs: assert property (@(posedge clk) disable iff (!rstn)
    (out_valid && !out_hit) |-> (out_idx == {IDX_W{1'b0}} && dataOut == DEFAULT_OUT));

  a_latency: assert property (@(posedge clk) disable iff (!rstn)
    out_valid |-> $past(in_valid, 2));

  a_saturate: assert property (@(posedge clk) disable iff (!rstn)
    (miss_count == {CNT_W{1'b1}} && !clr_cnt) |=> (miss_count == {CNT_W{1'b1}}));

endmodule

// File: rtl/casex_prio_enc.sv
// Lowest-index-wins priority encoder; idx is 0 when no bit is set.
module casex_prio_enc #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top so the lowest set bit is written last and wins
  always_comb begin
    any = 1'b0;
    idx = {IDX_W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        any = 1'b1;
        idx = IDX_W'(i);
      end else begin
        any = any;
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/casex_classifier.sv
// Programmable wildcard (casex-style) classifier: NUM_PAT value/mask entries,
// two-stage pipeline, lowest-index priority and a saturating miss counter.
module casex_classifier
  import casex_pkg::*;
#(
  parameter  int   WIDTH       = 3,
  parameter  int   NUM_PAT     = 4,
  parameter  int   CNT_W       = 8,
  parameter  logic DEFAULT_OUT = 1'b0,
  localparam int   IDX_W       = $clog2(NUM_PAT)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [WIDTH-1:0] cfg_value,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic             cfg_out,
  input  logic             cfg_en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_state,
  input  logic             clr_cnt,
  output logic             out_valid,
  output logic             dataOut,
  output logic             out_hit,
  output logic [IDX_W-1:0] out_idx,
  output logic [CNT_W-1:0] miss_count
);

  typedef struct packed {
    logic             en;
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] mask;
    logic             out;
  } tbl_entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  tbl_entry_t         tbl_r [NUM_PAT];
  logic               cfg_wr_s;
  logic [NUM_PAT-1:0] match_s;
  logic [NUM_PAT-1:0] outs_s;

  logic               s1_valid_r;
  logic [NUM_PAT-1:0] s1_match_r;
  logic [NUM_PAT-1:0] s1_outs_r;

  logic               any_s;
  logic [IDX_W-1:0]   idx_s;
  logic               miss_s;

  logic               out_valid_r;
  logic               data_r;
  logic               hit_r;
  logic [IDX_W-1:0]   idx_r;
  logic [CNT_W-1:0]   miss_count_r;

  assign cfg_wr_s = cfg_we && (int'(cfg_idx) < NUM_PAT);

  // Pattern table; a write lands on the edge and is seen by later samples only
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_PAT; i++) begin
        tbl_r[i] <= '0;
      end
    end else if (cfg_wr_s) begin
      tbl_r[cfg_idx] <= '{en: cfg_en, value: cfg_value, mask: cfg_mask, out: cfg_out};
    end
  end

  // Per-entry match against the current (pre-write) table
  always_comb begin
    match_s = {NUM_PAT{1'b0}};
    outs_s  = {NUM_PAT{1'b0}};
    for (int i = 0; i < NUM_PAT; i++) begin
      match_s[i] = tbl_r[i].en & pat_match(MATCH_W'(tbl_r[i].value),
                                           MATCH_W'(tbl_r[i].mask),
                                           MATCH_W'(in_state));
      outs_s[i]  = tbl_r[i].out;
    end
  end

  // Stage 1: match vector plus a snapshot of every entry's class bit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_r <= 1'b0;
      s1_match_r <= {NUM_PAT{1'b0}};
      s1_outs_r  <= {NUM_PAT{1'b0}};
    end else begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_match_r <= match_s;
        s1_outs_r  <= outs_s;
      end
    end
  end

  casex_prio_enc #(.N(NUM_PAT)) u_prio (
    .vec (s1_match_r),
    .any (any_s),
    .idx (idx_s)
  );

  assign miss_s = s1_valid_r & ~any_s;

  // Stage 2: registered result, held between valid pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_r <= 1'b0;
      data_r      <= DEFAULT_OUT;
      hit_r       <= 1'b0;
      idx_r       <= {IDX_W{1'b0}};
    end else begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        hit_r  <= any_s;
        idx_r  <= idx_s;
        data_r <= any_s ? s1_outs_r[idx_s] : DEFAULT_OUT;
      end
    end
  end

  // Saturating miss counter; a coincident miss survives a clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      miss_count_r <= {CNT_W{1'b0}};
    end else if (clr_cnt) begin
      miss_count_r <= miss_s ? CNT_ONE : {CNT_W{1'b0}};
    end else if (miss_s && (miss_count_r != CNT_MAX)) begin
      miss_count_r <= miss_count_r + CNT_ONE;
    end
  end

  assign out_valid  = out_valid_r;
  assign dataOut    = data_r;
  assign out_hit    = hit_r;
  assign out_idx    = idx_r;
  assign miss_count = miss_count_r;

  casex_classifier_chk #(
    .IDX_W       (IDX_W),
    .CNT_W       (CNT_W),
    .DEFAULT_OUT (DEFAULT_OUT)
  ) u_chk (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .clr_cnt    (clr_cnt),
    .out_valid  (out_valid),
    .out_hit    (out_hit),
    .out_idx    (out_idx),
    .dataOut    (dataOut),
    .miss_count (miss_count)
  );

endmodule

// File: tb/tb_casex_classifier.sv
// Directed bench for casex_classifier with a sample-level reference model.
module tb_casex_classifier;

  localparam int   WIDTH   = 3;
  localparam int   NUM_PAT = 4;
  localparam int   CNT_W   = 2;
  localparam int   IDX_W   = 2;
  localparam logic DEF     = 1'b0;

  logic             clk       = 1'b0;
  logic             rstn      = 1'b0;
  logic             cfg_we    = 1'b0;
  logic [IDX_W-1:0] cfg_idx   = 2'd0;
  logic [WIDTH-1:0] cfg_value = 3'd0;
  logic [WIDTH-1:0] cfg_mask  = 3'd0;
  logic             cfg_out   = 1'b0;
  logic             cfg_en    = 1'b0;
  logic             in_valid  = 1'b0;
  logic [WIDTH-1:0] in_state  = 3'd0;
  logic             clr_cnt   = 1'b0;
  logic             out_valid, dataOut, out_hit;
  logic [IDX_W-1:0] out_idx;
  logic [CNT_W-1:0] miss_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  casex_classifier #(
    .WIDTH(WIDTH), .NUM_PAT(NUM_PAT), .CNT_W(CNT_W), .DEFAULT_OUT(DEF)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_value(cfg_value), .cfg_mask(cfg_mask),
    .cfg_out(cfg_out), .cfg_en(cfg_en),
    .in_valid(in_valid), .in_state(in_state), .clr_cnt(clr_cnt),
    .out_valid(out_valid), .dataOut(dataOut), .out_hit(out_hit),
    .out_idx(out_idx), .miss_count(miss_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic             m_en  [NUM_PAT];
  logic [WIDTH-1:0] m_val [NUM_PAT];
  logic [WIDTH-1:0] m_msk [NUM_PAT];
  logic             m_out [NUM_PAT];
  logic             p_valid, p_hit, p_out;
  logic [IDX_W-1:0] p_idx;
  logic             e_valid, e_data, e_hit;
  logic [IDX_W-1:0] e_idx;
  int               e_cnt;

  // first enabled entry (top-to-bottom) whose cared-about bits agree, else -1
  function automatic int classify(input logic [WIDTH-1:0] s);
    for (int i = 0; i < NUM_PAT; i++) begin
      if (m_en[i] && (((s ^ m_val[i]) & m_msk[i]) == 3'b000)) return i;
    end
    return -1;
  endfunction

  function automatic int next_cnt(input int c, input logic miss, input logic clr);
    int maxv = (1 << CNT_W) - 1;
    if (clr) return miss ? 1 : 0;
    if (miss) return (c + 1 > maxv) ? maxv : c + 1;
    return c;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_PAT; i++) begin
        m_en[i] <= 1'b0; m_val[i] <= 3'd0; m_msk[i] <= 3'd0; m_out[i] <= 1'b0;
      end
      p_valid <= 1'b0; p_hit <= 1'b0; p_out <= 1'b0; p_idx <= 2'd0;
      e_valid <= 1'b0; e_data <= DEF; e_hit <= 1'b0; e_idx <= 2'd0; e_cnt <= 0;
    end else begin
      p_valid <= in_valid;
      if (in_valid) begin
        p_hit <= (classify(in_state) >= 0);
        p_idx <= (classify(in_state) >= 0) ? 2'(classify(in_state)) : 2'd0;
        p_out <= (classify(in_state) >= 0) ? m_out[classify(in_state)] : DEF;
      end
      e_valid <= p_valid;
      if (p_valid) begin
        e_hit  <= p_hit;
        e_idx  <= p_hit ? p_idx : 2'd0;
        e_data <= p_hit ? p_out : DEF;
      end
      e_cnt <= next_cnt(e_cnt, p_valid && !p_hit, clr_cnt);
      if (cfg_we && (int'(cfg_idx) < NUM_PAT)) begin
        m_en[cfg_idx] <= cfg_en; m_val[cfg_idx] <= cfg_value;
        m_msk[cfg_idx] <= cfg_mask; m_out[cfg_idx] <= cfg_out;
      end
    end
  end

  // every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    chk("cmp_out_valid", 32'(out_valid), 32'(e_valid));
    chk("cmp_dataOut", 32'(dataOut), 32'(e_data));
    chk("cmp_out_hit", 32'(out_hit), 32'(e_hit));
    chk("cmp_out_idx", 32'(out_idx), 32'(e_idx));
    chk("cmp_miss_count", 32'(miss_count), 32'(e_cnt));
  end

  // ---------------- stimulus ----------------
  task automatic wr(input int idx, input logic en, input logic [2:0] v,
                    input logic [2:0] m, input logic o);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_en = en; cfg_value = v; cfg_mask = m; cfg_out = o;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic sample(input logic [2:0] s);
    in_valid = 1'b1; in_state = s;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int max, input string tag);
    int k = 0;
    while (!out_valid && k < max) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_seen"}, 32'(out_valid), 32'd1);
  endtask

  task automatic check_res(input string tag, input logic hit, input logic [1:0] idx,
                           input logic d);
    chk({tag, "_hit"}, 32'(out_hit), 32'(hit));
    chk({tag, "_idx"}, 32'(out_idx), 32'(idx));
    chk({tag, "_data"}, 32'(dataOut), 32'(d));
  endtask

  int exp_d [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
  int exp_i [8] = '{0, 1, 2, 2, 3, 3, 3, 3};
  int exp_c [5] = '{1, 2, 3, 3, 3};

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    check_res("rst", 1'b0, 2'd0, 1'b0);
    chk("rst_cnt", 32'(miss_count), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // empty table -> miss
    sample(3'b101);
    wait_out(4, "empty");
    check_res("empty", 1'b0, 2'd0, 1'b0);
    chk("empty_cnt", 32'(miss_count), 32'd1);
    repeat (2) @(negedge clk);

    // legacy table, streamed back-to-back
    wr(0, 1'b1, 3'b000, 3'b111, 1'b1);
    wr(1, 1'b1, 3'b001, 3'b111, 1'b1);
    wr(2, 1'b1, 3'b010, 3'b110, 1'b0);
    wr(3, 1'b1, 3'b100, 3'b100, 1'b0);
    for (int j = 0; j < 10; j++) begin
      if (j >= 2) begin
        chk("stream_valid", 32'(out_valid), 32'd1);
        chk("stream_data", 32'(dataOut), 32'(exp_d[j-2]));
        chk("stream_idx", 32'(out_idx), 32'(exp_i[j-2]));
      end
      if (j < 8) begin
        in_valid = 1'b1; in_state = 3'(j);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("stream_end_valid", 32'(out_valid), 32'd0);

    // overlapping entries: lowest index wins
    wr(1, 1'b1, 3'b000, 3'b000, 1'b1);
    wr(3, 1'b1, 3'b111, 3'b111, 1'b0);
    sample(3'b111);
    wait_out(4, "prio");
    check_res("prio", 1'b1, 2'd1, 1'b1);
    @(negedge clk);

    // write coincident with a sample: sample sees the old table
    wr(1, 1'b1, 3'b001, 3'b111, 1'b1);
    wr(3, 1'b1, 3'b100, 3'b100, 1'b0);
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_en = 1'b1; cfg_value = 3'b011;
    cfg_mask = 3'b111; cfg_out = 1'b1;
    in_valid = 1'b1; in_state = 3'b011;
    @(negedge clk);
    cfg_we = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check_res("wr_old", 1'b1, 2'd2, 1'b0);
    @(negedge clk);
    check_res("wr_new", 1'b1, 2'd0, 1'b1);
    @(negedge clk);

    // miss counter: clear, saturate, clear coincident with a miss
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk("clr_alone", 32'(miss_count), 32'd0);
    for (int i = 0; i < NUM_PAT; i++) wr(i, 1'b0, 3'b000, 3'b000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      sample(3'b010);
      wait_out(4, "miss");
      chk("miss_cnt", 32'(miss_count), 32'(exp_c[k]));
      @(negedge clk);
    end
    in_valid = 1'b1; in_state = 3'b110;
    @(negedge clk);
    in_valid = 1'b0; clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk("clr_miss_valid", 32'(out_valid), 32'd1);
    chk("clr_miss_cnt", 32'(miss_count), 32'd1);
    @(negedge clk);

    // reset with samples in the pipeline
    wr(0, 1'b1, 3'b000, 3'b000, 1'b1);
    in_valid = 1'b1; in_state = 3'b101;
    @(negedge clk);
    in_state = 3'b110;
    @(negedge clk);
    in_valid = 1'b0;
    check_res("pre_rst", 1'b1, 2'd0, 1'b1);
    #2 rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    check_res("post_rst", 1'b0, 2'd0, 1'b0);
    chk("post_rst_cnt", 32'(miss_count), 32'd0);
    sample(3'b101);
    wait_out(4, "post_rst_tbl");
    check_res("post_rst_tbl", 1'b0, 2'd0, 1'b0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
